// File: rtl/aes256_encrypt_core.sv
// AES-256 encryption core: iterative, one cipher round per clock, round keys
// fetched combinationally from an external key store through rk_idx/rk_data.
module aes256_encrypt_core #(
  parameter  int unsigned NR = 14,
  localparam int unsigned BW = 128,
  localparam int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  output logic [CW-1:0] rk_idx,
  input  logic [BW-1:0] rk_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic          busy
);

  localparam logic [CW-1:0] LAST_RND = CW'(NR);

  // FIPS-197 S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   data_q, data_d;
  logic            in_ready_d, out_valid_d, busy_d;
  logic [CW-1:0]   rk_idx_d;
  logic [BW-1:0]   sr_c, mc_c, round_c;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes and ShiftRows: row r of column c takes the byte from column c+r
  always_comb begin
    sr_c = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_c[BW-1-8*(4*c+r) -: 8] = sub_byte(data_q[BW-1-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
  end

  // MixColumns, skipped on the final round, then AddRoundKey
  always_comb begin
    mc_c = '0;
    for (int c = 0; c < 4; c++) begin
      mc_c[BW-1-32*c -: 32] = mix_col(sr_c[BW-1-32*c -: 32]);
    end
    round_c = ((cnt_q == LAST_RND) ? sr_c : mc_c) ^ rk_data;
  end

  // Next-state, datapath update and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data ^ rk_data;
          cnt_d   = CW'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = round_c;
        if (cnt_q == LAST_RND) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    rk_idx_d    = (state_d == ROUND) ? cnt_d : '0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rk_idx    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      rk_idx    <= rk_idx_d;
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Directed and random bench for aes256_encrypt_core with a behavioural AES-256 model.
module tb_aes256_encrypt_core;

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks;
  int errors;

  logic [7:0]   sbox_m [256];
  logic [127:0] rkeys  [16];

  aes256_encrypt_core #(.NR(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rk_idx   (rk_idx),
    .rk_data  (rk_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-key store answering rk_idx in the same cycle
  always_comb rk_data = rkeys[rk_idx];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (8'({x[6:0], 1'b0}) ^ 8'h1b) : 8'({x[6:0], 1'b0});
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from multiplicative inverse plus affine transform
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = 8'({rcon[6:0], 1'b0});
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) rkeys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    rkeys[15] = '0;
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt);
    logic [127:0] st;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    st = pt ^ rkeys[0];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i];
      st = st ^ rkeys[rnd];
    end
    return st;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Directed sequence followed by random traffic
  initial begin
    int n;
    int nv;
    int guard;
    logic hs;
    logic [127:0] pt_a, pt_b, pt_c;
    logic [255:0] key;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    build_sbox();
    expand(KEY_C3);

    repeat (2) step();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_rk_idx", 128'(rk_idx), 128'd0);

    // FIPS-197 C.3 with rk_idx trace and in_data scrambled after acceptance
    in_data = PT_C3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    chk("run_busy", 128'(busy), 128'd1);
    chk("run_in_ready", 128'(in_ready), 128'd0);
    for (int k = 1; k <= 14; k++) begin
      chk("trace_rk_idx", 128'(rk_idx), 128'(k));
      chk("trace_no_valid", 128'(out_valid), 128'd0);
      step();
    end
    chk("c3_out_valid", 128'(out_valid), 128'd1);
    chk("c3_out_data", out_data, CT_C3);
    chk("done_rk_idx", 128'(rk_idx), 128'd0);
    chk("done_in_ready", 128'(in_ready), 128'd0);
    chk("done_busy", 128'(busy), 128'd1);

    // Backpressure with a competing block offered
    in_valid = 1'b1;
    in_data = 128'h0f0e0d0c0b0a09080706050403020100;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_data", out_data, CT_C3);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    chk("hs_out_valid", 128'(out_valid), 128'd0);
    chk("hs_in_ready", 128'(in_ready), 128'd1);
    chk("hs_not_accepted", 128'(busy), 128'd0);
    chk("hs_rk_idx", 128'(rk_idx), 128'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Back-to-back blocks with in_valid held high and out_ready high
    pt_a = rand128();
    pt_b = rand128();
    in_data = pt_a;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    chk("b2b_a_busy", 128'(busy), 128'd1);
    in_data = pt_b;
    wait_valid(n);
    chk("b2b_a_latency", 128'(n), 128'd14);
    chk("b2b_a_data", out_data, aes_model(pt_a));
    step();
    chk("b2b_gap_in_ready", 128'(in_ready), 128'd1);
    chk("b2b_gap_busy", 128'(busy), 128'd0);
    step();
    chk("b2b_b_busy", 128'(busy), 128'd1);
    chk("b2b_b_rk_idx", 128'(rk_idx), 128'd1);
    in_valid = 1'b0;
    wait_valid(n);
    chk("b2b_b_latency", 128'(n), 128'd14);
    chk("b2b_b_data", out_data, aes_model(pt_b));
    step();
    out_ready = 1'b0;

    // Asynchronous reset during round 7
    in_data = rand128();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("mid_rk_idx7", 128'(rk_idx), 128'd7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_rk_idx", 128'(rk_idx), 128'd0);
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_out_data", out_data, 128'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    nv = 0;
    repeat (20) begin
      step();
      if (out_valid) nv++;
    end
    chk("arst_no_valid", 128'(nv), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    pt_c = rand128();
    in_data = pt_c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(n);
    chk("post_rst_latency", 128'(n), 128'd14);
    chk("post_rst_data", out_data, aes_model(pt_c));
    step();
    out_ready = 1'b0;

    // Random keys and plaintexts with random out_ready
    for (int b = 0; b < 1000; b++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      expand(key);
      pt_a = rand128();
      in_data = pt_a;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_valid(n);
      chk("rand_out_valid", 128'(out_valid), 128'd1);
      chk("rand_out_data", out_data, aes_model(pt_a));
      hs = 1'b0;
      guard = 0;
      while (!hs) begin
        out_ready = (guard >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        hs = out_ready;
        step();
        guard++;
      end
      out_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
